id_skid_stage: RTL
==================

ID_SKID_STAGE -- requirements
Module: id_skid_stage

Interface
REQ-001 Parameter: NOP_INSTR, default 32'h0000_0000, word held in output register after reset/flush.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 flush  input  1  discard all held entries (branch/jump redirect).
REQ-005 in_valid  input  1  fetch presents an instruction.
REQ-006 in_ready  output  1  stage can accept; registered, high when skid entry empty.
REQ-007 in_instr  input  32  fetched instruction word.
REQ-008 in_pc4  input  32  PC+4 of that instruction.
REQ-009 out_valid  output  1  decoded entry available to the extend/execute stage.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_pc4  output  32  PC+4 of the presented entry.
REQ-012 out_opcode / out_rs / out_rt / out_rd / out_shamt / out_funct  output  6/5/5/5/5/6  instr[31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0].
REQ-013 out_immediate  output  16  instr[15:0]; feeds the sign/zero extender.
REQ-014 out_sext  output  1  extension mode for out_immediate: 1 = sign, 0 = zero.

Function
REQ-015 Storage SHALL be a main register plus one skid register, each with its own valid bit; outputs always driven from the main register.
REQ-016 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-017 Latency: an accepted instruction SHALL appear on out_* on the cycle after acceptance when the main register is empty or draining.
REQ-018 Acceptance while main is full and not draining SHALL load the skid register; in_ready drops the following cycle.
REQ-019 When main drains and skid is valid, skid SHALL move to main in the same edge; if a new input is also accepted that edge, it loads skid.
REQ-020 Program order SHALL be preserved; no entry duplicated or dropped absent flush.
REQ-021 States: EMPTY (no valid), ONE (main valid), FULL (main+skid valid); EMPTY->ONE on accept; ONE->FULL on accept without drain; ONE->EMPTY on drain without accept; FULL->ONE on drain without accept; FULL stays FULL on simultaneous drain and accept is impossible (in_ready=0).
REQ-022 out_sext SHALL be 1 for opcodes 0x04,0x05,0x08,0x09,0x0A,0x0B,0x23,0x2B; 0 for 0x0C,0x0D,0x0E,0x0F and all others, computed from the registered instruction.
REQ-023 flush SHALL clear both valid bits at the next edge, load NOP_INSTR into main, and take priority over any simultaneous accept or drain; in_ready is 1 the following cycle.
REQ-024 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-025 in_instr/in_pc4 SHALL be ignored when in_valid=0.

Reset
REQ-026 rst SHALL asynchronously clear both valid bits, set in_ready=1, out_valid=0, main instruction=NOP_INSTR (fields all zero, out_sext=0), out_pc4=0.
REQ-027 rst asserted mid-transfer SHALL discard all held entries; first accept after deassertion behaves as from EMPTY.

Structure
REQ-028 Opcode constants (OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW) SHALL live in shared package mips_pkg.
REQ-029 Opcode-to-sext mapping SHALL be a combinational sub-module sext_ctrl (input opcode[5:0], output sext).

Verification
REQ-030 Reset then accept in_instr=32'h2008FFFF (addi), pc4=0x4, out_ready=1 -> next cycle out_valid=1, opcode=0x08, rt=8, immediate=16'hFFFF, out_sext=1, out_pc4=0x4.
REQ-031 Accept 32'h3408_8000 (ori) -> out_sext=0, immediate=16'h8000.
REQ-032 out_ready=0, feed A then B back-to-back -> A held on outputs, B in skid, in_ready=0; release out_ready -> A then B on consecutive cycles, in_ready=1 after B moves to main.
REQ-033 FULL state, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, new word not captured.
REQ-034 Assert rst asynchronously mid-stream (between edges) -> out_valid falls immediately, in_ready=1, fields zero.
REQ-035 Random in_valid/out_ready stream of 1000 sequential pc4 values -> scoreboard shows in-order, no loss, no duplication.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants plus the decode-stage entry and occupancy types.
package mips_pkg;

  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } id_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/sext_ctrl.sv
// Immediate extension mode from opcode: arithmetic, compare, branch and memory
// offsets sign-extend; logical immediates and LUI zero-extend.
module sext_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       sext
);

  always_comb begin
    sext = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_SLTIU, OP_LW, OP_SW:    sext = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:   sext = 1'b0;
      default:                            sext = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_skid_stage.sv
// Decode pipeline stage: main output register plus one skid entry so in_ready
// can be a flop without losing the instruction in flight when downstream stalls.
module id_skid_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc4,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [5:0]  out_funct,
  output logic [15:0] out_immediate,
  output logic        out_sext
);

  id_entry_t   main_q, main_d, skid_q, skid_d, in_entry;
  logic        main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic        in_ready_q, in_ready_d;
  logic        accept, drain;
  skid_state_t state;

  // Occupancy view of the two valid bits; skid is only ever valid behind main.
  always_comb begin
    if (skid_vld_q)      state = ST_FULL;
    else if (main_vld_q) state = ST_ONE;
    else                 state = ST_EMPTY;
  end

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    in_entry   = '{instr: in_instr, pc4: in_pc4};
    accept     = in_valid && in_ready_q;
    drain      = main_vld_q && out_ready;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      main_d     = '{instr: NOP_INSTR, pc4: 32'h0};
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_d     = in_entry;
            main_vld_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (drain && accept) begin
            main_d = in_entry;
          end else if (drain) begin
            main_vld_d = 1'b0;
          end else if (accept) begin
            skid_d     = in_entry;
            skid_vld_d = 1'b1;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
            if (accept) begin
              skid_d     = in_entry;
              skid_vld_d = 1'b1;
            end
          end
        end
        default: begin
          main_vld_d = 1'b0;
          skid_vld_d = 1'b0;
        end
      endcase
    end

    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '{instr: NOP_INSTR, pc4: 32'h0};
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_vld_q;
  assign out_pc4       = main_q.pc4;
  assign out_opcode    = main_q.instr[31:26];
  assign out_rs        = main_q.instr[25:21];
  assign out_rt        = main_q.instr[20:16];
  assign out_rd        = main_q.instr[15:11];
  assign out_shamt     = main_q.instr[10:6];
  assign out_funct     = main_q.instr[5:0];
  assign out_immediate = main_q.instr[15:0];

  sext_ctrl u_sext_ctrl (
    .opcode (main_q.instr[31:26]),
    .sext   (out_sext)
  );

endmodule
